// File: rtl/zero_pattern_gen.sv
// zero_pattern_gen
// Enumerates, in ascending numeric order, every 8-bit word containing exactly
// N zero bits (N = zcount, 0..8). Words are presented one per handshake on a
// valid/ready stream. The generator is the inverse of the zero-count datapath.
// It drives that datapath with stimulus and feeds the count/compare blocks
// with exhaustive patterns.

module zero_pattern_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       zcount,
    input  logic             abort,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pattern,
    output logic [6:0]       pattern_idx,
    output logic             last,
    output logic             done,
    output logic             err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] top_word;
    logic [WIDTH-1:0] succ_src;
    logic [WIDTH-1:0] low_bit;
    logic [WIDTH-1:0] ripple;
    logic [WIDTH-1:0] next_pattern;
    logic [2:0]       trail;

    // The stream is valid exactly while enumerating. The final word is the one
    // whose ones have all migrated to the top of the byte.
    assign busy      = (state == ST_EMIT);
    assign out_valid = (state == ST_EMIT);
    assign last      = (state == ST_EMIT) && (pattern == top_word);

    // Compute the next word with the same popcount. The low run of ones is
    // carried upward by one position, and the leftover ones are repacked at
    // the bottom. The operand is forced to zero on the final word, so the
    // addition can never carry out of 8 bits.
    always_comb begin
        succ_src = last ? '0 : pattern;
        low_bit  = succ_src & (~succ_src + 1'b1);
        trail    = 3'd0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (succ_src[i]) begin
                trail = 3'(i);
            end
        end
        ripple       = succ_src + low_bit;
        next_pattern = ripple | (((succ_src ^ ripple) >> 2) >> trail);
    end

    // Control FSM with pattern registers. Abort overrides a same-cycle transfer.
    // done and err are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pattern     <= '0;
            pattern_idx <= '0;
            top_word    <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    if (zcount <= 4'd8) begin
                        state       <= ST_EMIT;
                        pattern     <= {WIDTH{1'b1}} >> zcount;
                        top_word    <= {WIDTH{1'b1}} << zcount;
                        pattern_idx <= '0;
                    end else begin
                        err <= 1'b1;
                    end
                end
            end else begin
                if (abort) begin
                    state <= ST_IDLE;
                end else if (out_ready) begin
                    if (last) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end else begin
                        pattern     <= next_pattern;
                        pattern_idx <= pattern_idx + 7'd1;
                    end
                end
            end
        end
    end

endmodule
